// File: rtl/md_if.sv
// E-stage to multiply/divide scheduler handshake: issue request, D-stage hazard
// query, and the committed HI/LO state.
interface md_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        md_use_d;
  logic        busy;
  logic        stall_md;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b, md_use_d,
    input  busy, stall_md, hi, lo
  );

  modport slave (
    input  start, op, a, b, md_use_d,
    output busy, stall_md, hi, lo
  );
endinterface

// File: rtl/md_sched.sv
// Fixed-latency multiply/divide scheduler: owns HI/LO, computes the result at issue
// and holds it back until the latency counter expires.
module md_sched #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input logic clk,
    input logic reset,
    md_if.slave bus
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW = ($clog2(MaxCycles + 1) > 4) ? $clog2(MaxCycles + 1) : 4;

    typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

    state_e         state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]    hi_q, hi_d;
    logic [31:0]    lo_q, lo_d;
    logic [31:0]    pend_hi_q, pend_hi_d;
    logic [31:0]    pend_lo_q, pend_lo_d;
    logic           pend_we_q, pend_we_d;

    logic        signed_op;
    logic [63:0] mul_a, mul_b, product;
    logic        neg_a, neg_b;
    logic [31:0] mag_a, mag_b, uquot, urem, quot, rem;
    logic        busy;

    // Even opcodes (MULT, DIV) are the signed variants.
    assign signed_op = ~bus.op[0];

    // Sign-extending to 64 bits makes the truncated unsigned product correct for MULT.
    assign mul_a   = signed_op ? {{32{bus.a[31]}}, bus.a} : {32'd0, bus.a};
    assign mul_b   = signed_op ? {{32{bus.b[31]}}, bus.b} : {32'd0, bus.b};
    assign product = mul_a * mul_b;

    // Signed divide via magnitudes; 0x80000000 / -1 falls out as quotient 0x80000000.
    assign neg_a = signed_op & bus.a[31];
    assign neg_b = signed_op & bus.b[31];
    assign mag_a = neg_a ? 32'd0 - bus.a : bus.a;
    assign mag_b = neg_b ? 32'd0 - bus.b : bus.b;
    assign uquot = (mag_b == 32'd0) ? 32'd0 : mag_a / mag_b;
    assign urem  = (mag_b == 32'd0) ? 32'd0 : mag_a % mag_b;
    assign quot  = (neg_a ^ neg_b) ? 32'd0 - uquot : uquot;
    assign rem   = neg_a ? 32'd0 - urem : urem;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_we_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_we_q <= pend_we_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_we_d = pend_we_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    case (bus.op)
                        3'd0, 3'd1: begin
                            pend_hi_d = product[63:32];
                            pend_lo_d = product[31:0];
                            pend_we_d = 1'b1;
                            cnt_d     = CntW'(MULT_CYCLES);
                            state_d   = StMul;
                        end
                        3'd2, 3'd3: begin
                            pend_hi_d = rem;
                            pend_lo_d = quot;
                            // Divide by zero still occupies the unit but never commits.
                            pend_we_d = |bus.b;
                            cnt_d     = CntW'(DIV_CYCLES);
                            state_d   = StDiv;
                        end
                        3'd4:    hi_d = bus.a;
                        3'd5:    lo_d = bus.a;
                        default: ;
                    endcase
                end
            end
            StMul, StDiv: begin
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StIdle;
                    if (pend_we_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy         = (state_q != StIdle);
    assign bus.busy     = busy;
    assign bus.stall_md = bus.md_use_d & (bus.start | busy);
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

endmodule

// File: tb/tb_md_sched.sv
// Directed self-checking bench for md_sched with default latencies (MULT 5, DIV 10).
module tb_md_sched;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    md_if bus ();

    md_sched #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one op at a negedge, then watch busy on every negedge until it drops.
    task automatic issue_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic use_d, output int cycles, output logic stall_start,
                            output logic stall_all, output logic stall_any,
                            output logic stall_after, output logic hilo_moved);
        logic [31:0] hi0, lo0;
        @(negedge clk);
        hi0 = bus.hi;
        lo0 = bus.lo;
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b; bus.md_use_d = use_d;
        #1 stall_start = bus.stall_md;
        @(posedge clk);
        #1 bus.start = 1'b0;
        cycles = 0; stall_all = 1'b1; stall_any = 1'b0; hilo_moved = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
            cycles++;
            stall_all  = stall_all & bus.stall_md;
            stall_any  = stall_any | bus.stall_md;
            hilo_moved = hilo_moved | (bus.hi !== hi0) | (bus.lo !== lo0);
        end
        stall_after = bus.stall_md;
    endtask

    task automatic test_reset();
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %h want 0", bus.busy); end
        n_checks++; if (bus.hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi got %h want 0", bus.hi); end
        n_checks++; if (bus.lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo got %h want 0", bus.lo); end
        bus.md_use_d = 1'b1; bus.start = 1'b1; #1;
        n_checks++; if (bus.stall_md !== 1'b1) begin n_fail++; $display("FAIL reset_stall_start got %h want 1", bus.stall_md); end
        bus.start = 1'b0; #1;
        n_checks++; if (bus.stall_md !== 1'b0) begin n_fail++; $display("FAIL reset_stall_idle got %h want 0", bus.stall_md); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_mult();
        int c; logic ss, sa, sy, sf, mv;
        issue_op(3'd0, 32'hFFFF_FFFD, 32'd7, 1'b1, c, ss, sa, sy, sf, mv);
        n_checks++; if (c !== 5) begin n_fail++; $display("FAIL mult_busy_cycles got %0d want 5", c); end
        n_checks++; if (ss !== 1'b1) begin n_fail++; $display("FAIL mult_stall_start got %h want 1", ss); end
        n_checks++; if (sa !== 1'b1) begin n_fail++; $display("FAIL mult_stall_busy got %h want 1", sa); end
        n_checks++; if (sf !== 1'b0) begin n_fail++; $display("FAIL mult_stall_after got %h want 0", sf); end
        n_checks++; if (mv !== 1'b0) begin n_fail++; $display("FAIL mult_early_commit got %h want 0", mv); end
        n_checks++; if (bus.hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi got %h want ffffffff", bus.hi); end
        n_checks++; if (bus.lo !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mult_lo got %h want ffffffeb", bus.lo); end
    endtask

    task automatic test_divu();
        int c; logic ss, sa, sy, sf, mv;
        issue_op(3'd3, 32'd100, 32'd7, 1'b1, c, ss, sa, sy, sf, mv);
        n_checks++; if (c !== 10) begin n_fail++; $display("FAIL divu_busy_cycles got %0d want 10", c); end
        n_checks++; if (sa !== 1'b1) begin n_fail++; $display("FAIL divu_stall_busy got %h want 1", sa); end
        n_checks++; if (bus.lo !== 32'd14) begin n_fail++; $display("FAIL divu_lo got %h want 0000000e", bus.lo); end
        n_checks++; if (bus.hi !== 32'd2) begin n_fail++; $display("FAIL divu_hi got %h want 00000002", bus.hi); end
    endtask

    task automatic test_div_signed();
        int c; logic ss, sa, sy, sf, mv;
        issue_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1, c, ss, sa, sy, sf, mv);
        n_checks++; if (c !== 10) begin n_fail++; $display("FAIL div_busy_cycles got %0d want 10", c); end
        n_checks++; if (bus.lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_lo got %h want fffffffd", bus.lo); end
        n_checks++; if (bus.hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_hi got %h want ffffffff", bus.hi); end
    endtask

    task automatic test_div_overflow();
        int c; logic ss, sa, sy, sf, mv;
        issue_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, c, ss, sa, sy, sf, mv);
        n_checks++; if (bus.lo !== 32'h8000_0000) begin n_fail++; $display("FAIL divovf_lo got %h want 80000000", bus.lo); end
        n_checks++; if (bus.hi !== 32'd0) begin n_fail++; $display("FAIL divovf_hi got %h want 00000000", bus.hi); end
    endtask

    task automatic test_div_zero();
        int c; logic ss, sa, sy, sf, mv;
        issue_op(3'd5, 32'h55, 32'd0, 1'b1, c, ss, sa, sy, sf, mv);
        n_checks++; if (c !== 0) begin n_fail++; $display("FAIL mtlo_busy_cycles got %0d want 0", c); end
        n_checks++; if (bus.lo !== 32'h55) begin n_fail++; $display("FAIL mtlo_lo got %h want 00000055", bus.lo); end
        issue_op(3'd3, 32'd1234, 32'd0, 1'b1, c, ss, sa, sy, sf, mv);
        n_checks++; if (c !== 10) begin n_fail++; $display("FAIL divzero_busy_cycles got %0d want 10", c); end
        n_checks++; if (bus.lo !== 32'h55) begin n_fail++; $display("FAIL divzero_lo got %h want 00000055", bus.lo); end
        n_checks++; if (bus.hi !== 32'd0) begin n_fail++; $display("FAIL divzero_hi got %h want 00000000", bus.hi); end
    endtask

    task automatic test_no_stall();
        int c; logic ss, sa, sy, sf, mv;
        issue_op(3'd1, 32'd3, 32'd3, 1'b0, c, ss, sa, sy, sf, mv);
        n_checks++; if ((ss | sy | sf) !== 1'b0) begin n_fail++; $display("FAIL nostall_stall got %h want 0", ss | sy | sf); end
        n_checks++; if (bus.lo !== 32'd9) begin n_fail++; $display("FAIL nostall_lo got %h want 00000009", bus.lo); end
    endtask

    task automatic test_mthi();
        int c; logic ss, sa, sy, sf, mv;
        issue_op(3'd4, 32'h1234_5678, 32'd0, 1'b1, c, ss, sa, sy, sf, mv);
        n_checks++; if (c !== 0) begin n_fail++; $display("FAIL mthi_busy_cycles got %0d want 0", c); end
        n_checks++; if (bus.hi !== 32'h1234_5678) begin n_fail++; $display("FAIL mthi_hi got %h want 12345678", bus.hi); end
        n_checks++; if (bus.lo !== 32'd9) begin n_fail++; $display("FAIL mthi_lo got %h want 00000009", bus.lo); end
    endtask

    task automatic test_reset_mid();
        int c; logic ss, sa, sy, sf, mv;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'd5; bus.b = 32'd5;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %h want 0", bus.busy); end
        n_checks++; if (bus.hi !== 32'd0) begin n_fail++; $display("FAIL rstmid_hi got %h want 0", bus.hi); end
        n_checks++; if (bus.lo !== 32'd0) begin n_fail++; $display("FAIL rstmid_lo got %h want 0", bus.lo); end
        @(negedge clk);
        reset = 1'b1;
        issue_op(3'd1, 32'd2, 32'd3, 1'b1, c, ss, sa, sy, sf, mv);
        n_checks++; if (c !== 5) begin n_fail++; $display("FAIL rstmid_busy_cycles got %0d want 5", c); end
        n_checks++; if (bus.lo !== 32'd6) begin n_fail++; $display("FAIL rstmid_lo_after got %h want 00000006", bus.lo); end
        n_checks++; if (bus.hi !== 32'd0) begin n_fail++; $display("FAIL rstmid_hi_after got %h want 00000000", bus.hi); end
    endtask

    task automatic test_start_while_busy();
        int c;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd1; bus.a = 32'h8000_0000; bus.b = 32'd4;
        @(posedge clk);
        #1 bus.start = 1'b0;
        c = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
            c++;
            if (c == 2) begin
                bus.start = 1'b1; bus.op = 3'd5; bus.a = 32'h0000_DEAD;
            end else if (c == 3) begin
                n_checks++; if (bus.lo !== 32'd6) begin n_fail++; $display("FAIL swb_mtlo_dropped got %h want 00000006", bus.lo); end
                bus.op = 3'd0; bus.a = 32'd1; bus.b = 32'd1;
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        n_checks++; if (c !== 5) begin n_fail++; $display("FAIL swb_busy_cycles got %0d want 5", c); end
        n_checks++; if (bus.hi !== 32'd2) begin n_fail++; $display("FAIL swb_hi got %h want 00000002", bus.hi); end
        n_checks++; if (bus.lo !== 32'd0) begin n_fail++; $display("FAIL swb_lo got %h want 00000000", bus.lo); end
        @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL swb_idle_after got %h want 0", bus.busy); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        bus.start = 1'b0; bus.op = 3'd0; bus.a = 32'd0; bus.b = 32'd0; bus.md_use_d = 1'b0;
        #12;
        test_reset();
        test_mult();
        test_divu();
        test_div_signed();
        test_div_overflow();
        test_div_zero();
        test_no_stall();
        test_mthi();
        test_reset_mid();
        test_start_while_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/md_sched.md
# md_sched

Multiply/divide scheduler for the five-stage pipeline. Accepts one mult/div/mthi/mtlo operation per issue from the E stage and runs it as a fixed-latency operation. It owns the HI/LO registers and drives a stall request into the hazard logic, so that any D-stage HI/LO-related instruction is held while an operation is issuing or in flight.

## Interface
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (must be ≥1)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (must be ≥1)
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- start  in  1  E-stage instruction is an md op and valid this cycle
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6/7 reserved
- a  in  32  forwarded rs value from E stage
- b  in  32  forwarded rt value from E stage
- md_use_d  in  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- busy  out  1  operation in flight
- stall_md  out  1  combinational: md_use_d & (start | busy)
- hi  out  32  committed HI
- lo  out  32  committed LO

## Operation
- States: IDLE, MUL, DIV. Down-counter cnt is 4 bits wide, or wider if a parameter exceeds 15.
- IDLE + start + op∈{0,1}:
  - At the edge, compute the 64-bit product into pend_hi/pend_lo.
  - Load cnt=MULT_CYCLES and go to MUL.
  - MULT is signed; MULTU is unsigned.
- IDLE + start + op∈{2,3}:
  - At the edge, compute the quotient into pend_lo and the remainder into pend_hi.
  - Load cnt=DIV_CYCLES and go to DIV.
  - DIV is signed: truncate toward zero; remainder takes the sign of the dividend.
- IDLE + start + op=4: hi<=a at the edge, no busy. op=5: lo<=a at the edge, no busy.
- IDLE + start + op∈{6,7}: no effect.
- MUL/DIV behaviour each edge:
  - cnt decrements.
  - On the edge where cnt==1: hi<=pend_hi, lo<=pend_lo, state goes to IDLE.
- Divide by zero (b==0): a full DIV_CYCLES busy period runs, but hi/lo are NOT updated.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- start while busy: ignored, including MTHI/MTLO. The hazard logic guarantees this cannot occur; the block must still not corrupt state.
- busy = (state != IDLE), driven from a register.
- hi/lo only change at the commit edge or on an MTHI/MTLO edge.

## Timing
- Reset (reset=0, asynchronous): state=IDLE, cnt=0, busy=0, hi=0, lo=0, pend_hi/pend_lo=0. Combinationally, stall_md=md_use_d&start.
- Reset mid-operation: the in-flight result is discarded; hi/lo read 0 immediately.
- Mult issued at edge T0 (start=1 in the cycle before T0):
  - busy is high from T0 through T0+MULT_CYCLES.
  - hi/lo take the new value at edge T0+MULT_CYCLES, in the same edge where busy falls.
  - The first cycle in which an mfhi in D is not stalled is the cycle after edge T0+MULT_CYCLES.
- Div: same timing with DIV_CYCLES.
- stall_md is purely combinational and valid in the same cycle as start/busy/md_use_d.
- Back-to-back ops are not possible: a second md op in D is stalled during its predecessor's start cycle, so issue is one op per (latency+1) cycles minimum.
- MTHI/MTLO have a latency of 1 edge. The value is readable by mfhi/mflo in E at the next cycle; forwarding HI/LO is not required because stall_md covers the start cycle.

## Test plan
- MULT a=0xFFFFFFFD (-3), b=7:
  - busy stays high for exactly 5 edges.
  - After the 5th edge: hi=0xFFFFFFFF, lo=0xFFFFFFEB.
  - hi/lo remain 0 before that edge.
- DIVU a=100, b=7: busy for 10 cycles, then lo=14, hi=2.
- DIV a=-7, b=2: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=0x80000000, b=-1: lo=0x80000000, hi=0.
- Preload lo=0x55 via MTLO, then DIVU b=0: busy for 10 cycles; hi/lo are unchanged afterwards (lo=0x55).
- md_use_d=1:
  - With start=1: stall_md=1 in that cycle.
  - During each busy cycle: stall_md=1.
  - The cycle after commit: stall_md=0.
  - With md_use_d=0: stall_md=0 throughout.
- MTHI a=0x12345678 while idle: hi=0x12345678 after one edge, busy stays 0.
- Start MULT, drop reset low at the 3rd busy cycle: hi/lo/busy are 0 immediately. After reset is released, the block accepts a new MULTU 2*3 and gives lo=6, hi=0 after 5 cycles.
- Start asserted while busy (forced): the in-flight result still commits correctly and the second op is dropped.
